// File: rtl/query_pourer.sv
// query_pourer: fetches a packed 2-bit-per-base query from SRAM and pours it
// into the query buffer one base per cycle as {valid, base} symbols, framed
// by pouring_o / pouring_last_o, with backpressure from the buffer full flag.
// Optional feature macro: POURER_COMPLEMENT_EN adds comp_i, which complements
// every emitted base (A<->T, C<->G) for jobs accepted with comp_i=1.
// WORD_BASES must be a power of two.
module query_pourer #(
    parameter int unsigned WORD_BASES = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned LEN_W      = 12
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef POURER_COMPLEMENT_EN
    input  logic                    comp_i,
`endif
    input  logic                    start_i,
    input  logic [ADDR_W-1:0]       base_addr_i,
    input  logic [LEN_W-1:0]        len_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    rd_en_o,
    output logic [ADDR_W-1:0]       addr_o,
    input  logic [2*WORD_BASES-1:0] rdata_i,
    input  logic                    full_i,
    input  logic                    update_i,
    output logic [2:0]              q_o,
    output logic                    pouring_o,
    output logic                    pouring_last_o
);

    localparam int unsigned WORD_W = 2 * WORD_BASES;
    localparam int unsigned IDX_W  = $clog2(WORD_BASES);
    localparam int unsigned BIT_W  = $clog2(WORD_W);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_POUR  = 2'd2,
        ST_LAST  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_d;

    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_words_left;
    logic [IDX_W-1:0]   r_idx;
    logic [WORD_W-1:0]  r_cur;
    logic [WORD_W-1:0]  r_nxt;
    logic               r_cur_vld;
    logic               r_nxt_vld;
    logic               r_rd_pend;

    logic               w_accept;
    logic               w_push;
    logic               w_pop;
    logic               w_issue;
    logic [2:0]         w_occ;
    logic [LEN_W-1:0]   w_words;
    logic [WORD_W-1:0]  w_l0;
    logic [WORD_W-1:0]  w_l1;
    logic               w_l0v;
    logic               w_l1v;
    logic               w_l2v;
    logic [BIT_W-1:0]   w_bit;
    logic [1:0]         w_base;
    logic [1:0]         w_base_out;

    logic [2:0]         w_q_d;
    logic               w_pour_d;
    logic               w_last_d;
    logic               w_done_d;
    logic               w_busy_d;

    // Word queue view: stored cur/nxt followed by the word arriving from SRAM
    // this cycle; the arrival is bypassed to the head when nothing is stored.
    assign w_l0  = r_cur_vld ? r_cur : rdata_i;
    assign w_l0v = r_cur_vld | r_rd_pend;
    assign w_l1  = r_nxt_vld ? r_nxt : rdata_i;
    assign w_l1v = r_cur_vld & (r_nxt_vld | r_rd_pend);
    assign w_l2v = r_nxt_vld & r_rd_pend;

    assign w_bit  = {r_idx, 1'b0};
    assign w_base = w_l0[w_bit +: 2];

`ifdef POURER_COMPLEMENT_EN
    logic r_comp;

    // Complement select is latched per job at accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_comp <= 1'b0;
        end else if (w_accept) begin
            r_comp <= comp_i;
        end
    end

    assign w_base_out = w_base ^ {2{r_comp}};
`else
    assign w_base_out = w_base;
`endif

    assign w_accept = (r_state == ST_IDLE) & start_i;
    assign w_push   = (r_state == ST_POUR) & w_l0v & (r_len != '0) & (~full_i | update_i);
    assign w_pop    = w_push & (r_idx == IDX_W'(WORD_BASES - 1));
    assign w_words  = LEN_W'(((LEN_W + 1)'(len_i) + (LEN_W + 1)'(WORD_BASES - 1)) >> IDX_W);

    // Words held, arriving and requested, minus the one retired this cycle;
    // a new read only fits when at most one remains.
    assign w_occ   = 3'(r_cur_vld) + 3'(r_nxt_vld) + 3'(r_rd_pend) + 3'(rd_en_o) - 3'(w_pop);
    assign w_issue = ((r_state == ST_FETCH) | (r_state == ST_POUR)) &
                     (r_words_left != '0) & (w_occ < 3'd2);

    // Next state and next registered output values
    always_comb begin
        w_state_d = r_state;
        w_q_d     = 3'b000;
        w_pour_d  = pouring_o;
        w_last_d  = 1'b0;
        w_done_d  = 1'b0;
        w_busy_d  = busy_o;
        case (r_state)
            ST_IDLE: begin
                w_busy_d = 1'b0;
                if (start_i) begin
                    w_busy_d = 1'b1;
                    if (len_i == '0) begin
                        w_state_d = ST_LAST;
                        w_last_d  = 1'b1;
                        w_done_d  = 1'b1;
                    end else begin
                        w_state_d = ST_FETCH;
                    end
                end
            end
            ST_FETCH: begin
                w_state_d = ST_POUR;
            end
            ST_POUR: begin
                if (w_push) begin
                    w_q_d    = {1'b1, w_base_out};
                    w_pour_d = 1'b1;
                end
                if (r_len == '0) begin
                    w_state_d = ST_LAST;
                    w_pour_d  = 1'b0;
                    w_last_d  = 1'b1;
                    w_done_d  = 1'b1;
                end
            end
            ST_LAST: begin
                w_state_d = ST_IDLE;
                w_busy_d  = 1'b0;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    // State and buffer-side output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            q_o            <= 3'b000;
            pouring_o      <= 1'b0;
            pouring_last_o <= 1'b0;
            done_o         <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            r_state        <= w_state_d;
            q_o            <= w_q_d;
            pouring_o      <= w_pour_d;
            pouring_last_o <= w_last_d;
            done_o         <= w_done_d;
            busy_o         <= w_busy_d;
        end
    end

    // Read sequencing, word queue and base/length counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_en_o      <= 1'b0;
            addr_o       <= '0;
            r_rd_pend    <= 1'b0;
            r_len        <= '0;
            r_words_left <= '0;
            r_idx        <= '0;
            r_cur        <= '0;
            r_nxt        <= '0;
            r_cur_vld    <= 1'b0;
            r_nxt_vld    <= 1'b0;
        end else begin
            r_rd_pend <= rd_en_o;
            if (w_accept) begin
                r_len        <= len_i;
                r_idx        <= '0;
                r_cur_vld    <= 1'b0;
                r_nxt_vld    <= 1'b0;
                rd_en_o      <= (len_i != '0);
                addr_o       <= base_addr_i;
                r_words_left <= w_words - LEN_W'(len_i != '0);
            end else begin
                rd_en_o <= w_issue;
                if (w_issue) begin
                    addr_o       <= addr_o + ADDR_W'(1);
                    r_words_left <= r_words_left - LEN_W'(1);
                end
                if (w_pop) begin
                    r_cur     <= w_l1;
                    r_cur_vld <= w_l1v;
                    r_nxt     <= rdata_i;
                    r_nxt_vld <= w_l2v;
                end else begin
                    r_cur     <= w_l0;
                    r_cur_vld <= w_l0v;
                    r_nxt     <= w_l1;
                    r_nxt_vld <= w_l1v;
                end
                if (w_push) begin
                    r_len <= r_len - LEN_W'(1);
                    r_idx <= w_pop ? '0 : r_idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_query_pourer.sv
// Self-checking bench for query_pourer: table of jobs with hand-computed
// timing/read counts, an SRAM model supplying data, plus a mid-job reset.
module tb_query_pourer;

    logic        clk;
    logic        rst_n;
    logic        start_i;
    logic [15:0] base_addr_i;
    logic [11:0] len_i;
    logic        busy_o;
    logic        done_o;
    logic        rd_en_o;
    logic [15:0] addr_o;
    logic [31:0] rdata_i;
    logic        full_i;
    logic        update_i;
    logic [2:0]  q_o;
    logic        pouring_o;
    logic        pouring_last_o;
`ifdef POURER_COMPLEMENT_EN
    logic        comp_i;
`endif

    query_pourer dut (
        .clk            (clk),
        .rst_n          (rst_n),
`ifdef POURER_COMPLEMENT_EN
        .comp_i         (comp_i),
`endif
        .start_i        (start_i),
        .base_addr_i    (base_addr_i),
        .len_i          (len_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .rd_en_o        (rd_en_o),
        .addr_o         (addr_o),
        .rdata_i        (rdata_i),
        .full_i         (full_i),
        .update_i       (update_i),
        .q_o            (q_o),
        .pouring_o      (pouring_o),
        .pouring_last_o (pouring_last_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: 256 words, data one cycle after the read strobe
    logic [31:0] mem [256];
    always @(posedge clk) begin
        rdata_i <= rd_en_o ? mem[addr_o[7:0]] : 32'hA5A5_A5A5;
    end

    int n_chk;
    int n_pass;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [1:0] model_base(input logic [15:0] a, input int n);
        logic [15:0] wa;
        logic [31:0] w;
        wa = a + 16'(n / 16);
        w  = mem[wa[7:0]];
        return w[2 * (n % 16) +: 2];
    endfunction

    // mode: 0 no stall, 1 full without pop in cycles T+4..T+6, 2 full with pop
    typedef struct {
        logic [11:0] len;
        logic [15:0] addr;
        int          mode;
        int          exp_reads;
        int          exp_first;
        int          exp_last;
        int          exp_pour;
    } vec_t;

    vec_t vecs [8];

    // Start a job in the current cycle T and observe cycles T+1..T+exp_last
    task automatic run_job(input vec_t v);
        int n_reads, n_valid, first, last, n_last, done_c, pour_cnt, busy_cnt;
        int bad_q, bad_idle, bad_addr, pour_gap;
        @(negedge clk);
        chk("idle_before_start", int'(busy_o), 0);
        start_i     = 1'b1;
        len_i       = v.len;
        base_addr_i = v.addr;
        full_i      = (v.mode == 2);
        update_i    = (v.mode == 2);
        n_reads = 0; n_valid = 0; first = -1; last = -1; n_last = 0; done_c = -1;
        pour_cnt = 0; busy_cnt = 0; bad_q = 0; bad_idle = 0; bad_addr = 0; pour_gap = 0;
        for (int k = 1; k <= v.exp_last; k++) begin
            @(negedge clk);
            if (k == 1) start_i = 1'b0;
            if (rd_en_o) begin
                if (addr_o != 16'(v.addr + 16'(n_reads))) bad_addr++;
                n_reads++;
            end
            if (q_o[2]) begin
                if (q_o[1:0] != model_base(v.addr, n_valid)) bad_q++;
                if (!pouring_o) pour_gap++;
                if (first < 0) first = k;
                n_valid++;
            end else if (q_o != 3'b000) begin
                bad_idle++;
            end
            if (pouring_o) pour_cnt++;
            if (busy_o) busy_cnt++;
            if (pouring_last_o) begin
                if (last < 0) last = k;
                n_last++;
                if (pouring_o) pour_gap++;
            end
            if (done_o && done_c < 0) done_c = k;
            if (v.mode == 1) begin
                full_i   = (k >= 4 && k <= 6);
                update_i = 1'b0;
            end
            if (v.exp_last > 11 && k == 10) begin
                start_i     = 1'b1;
                len_i       = 12'd3;
                base_addr_i = 16'h0077;
            end
            if (k == 11) start_i = 1'b0;
        end
        start_i  = 1'b0;
        full_i   = 1'b0;
        update_i = 1'b0;
        chk("read_count", n_reads, v.exp_reads);
        chk("read_addr_seq", bad_addr, 0);
        chk("valid_count", n_valid, int'(v.len));
        chk("first_valid_cycle", first, v.exp_first);
        chk("q_data", bad_q, 0);
        chk("q_idle_zero", bad_idle, 0);
        chk("last_cycle", last, v.exp_last);
        chk("last_pulses", n_last, 1);
        chk("done_cycle", done_c, v.exp_last);
        chk("pouring_cycles", pour_cnt, v.exp_pour);
        chk("pouring_framing", pour_gap, 0);
        chk("busy_cycles", busy_cnt, v.exp_last);
    endtask

    initial begin
        vec_t rvec;
        n_chk  = 0;
        n_pass = 0;

        //            len     addr      mode reads first last pour
        vecs[0] = '{12'd5,  16'h0010, 0, 1,  3,  8,  5};
        vecs[1] = '{12'd0,  16'h0020, 0, 0, -1,  1,  0};
        vecs[2] = '{12'd40, 16'h0030, 0, 3,  3, 43, 40};
        vecs[3] = '{12'd8,  16'h0040, 1, 1,  3, 14, 11};
        vecs[4] = '{12'd20, 16'h0050, 2, 2,  3, 23, 20};
        vecs[5] = '{12'd16, 16'h0060, 0, 1,  3, 19, 16};
        vecs[6] = '{12'd17, 16'hFFFF, 0, 2,  3, 20, 17};
        vecs[7] = '{12'd1,  16'h0070, 0, 1,  3,  4,  1};
        rvec    = '{12'd2,  16'h0090, 0, 1,  3,  5,  2};

        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_1234;
        end
        // Word 0x10 bases 0..4 = 1,2,3,0,1
        mem[16] = {mem[16][31:10], 10'b01_00_11_10_01};

        rst_n       = 1'b0;
        start_i     = 1'b0;
        base_addr_i = '0;
        len_i       = '0;
        full_i      = 1'b0;
        update_i    = 1'b0;
`ifdef POURER_COMPLEMENT_EN
        comp_i      = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_q", int'(q_o), 0);
        chk("rst_pouring", int'(pouring_o), 0);
        chk("rst_last", int'(pouring_last_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        chk("rst_rd_en", int'(rd_en_o), 0);
        chk("rst_addr", int'(addr_o), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_job(vecs[i]);
        end

        // Reset in the middle of a len=20 job, then a fresh short job
        @(negedge clk);
        start_i     = 1'b1;
        len_i       = 12'd20;
        base_addr_i = 16'h0080;
        @(negedge clk);
        start_i = 1'b0;
        repeat (6) @(negedge clk);
        chk("mid_job_pouring", int'(pouring_o), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_q", int'(q_o), 0);
        chk("abort_pouring", int'(pouring_o), 0);
        chk("abort_last", int'(pouring_last_o), 0);
        chk("abort_done", int'(done_o), 0);
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_rd_en", int'(rd_en_o), 0);
        chk("abort_addr", int'(addr_o), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_job(rvec);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
